// File: rtl/mips_muldiv.sv
// MIPS HI/LO multiply/divide unit: iterative 32-cycle shift-add multiply and
// restoring divide, followed by a one-cycle sign fix-up that commits {hi,lo}.
module mips_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mf_req,
  input  logic        mf_sel,
  output logic [31:0] mf_data,
  output logic        md_busy,
  output logic        md_stall,
  output logic        md_done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] rs_raw_q, rs_raw_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        op_signed;
  logic [31:0] rs_abs;
  logic [31:0] rt_abs;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_rem;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] div_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (md_start) begin
          if (md_op == OP_MULT || md_op == OP_MULTU) begin
            state_d = S_MUL;
          end else if (md_op == OP_DIV || md_op == OP_DIVU) begin
            state_d = S_DIV;
          end
        end
      end
      S_MUL:   if (cnt_q == 5'd0) state_d = S_FIX;
      S_DIV:   if (cnt_q == 5'd0) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    md_busy   = (state_q != S_IDLE);
    dbg_state = state_q;
  end

  // Operand conditioning: signed ops iterate on magnitudes
  always_comb begin
    op_signed = (md_op == OP_MULT) || (md_op == OP_DIV);
    rs_abs    = (op_signed && rs_data[31]) ? (32'd0 - rs_data) : rs_data;
    rt_abs    = (op_signed && rt_data[31]) ? (32'd0 - rt_data) : rt_data;
  end

  // Multiply step: acc holds {partial_hi, remaining multiplier bits}
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
  end

  // Restoring divide step: acc holds {partial remainder, dividend/quotient}
  always_comb begin
    div_rem  = {acc_q[63:32], acc_q[31]};
    div_ge   = (div_rem >= {1'b0, opb_q});
    div_sub  = div_rem[31:0] - opb_q;
    div_next = div_ge ? {div_sub, acc_q[30:0], 1'b1}
                      : {div_rem[31:0], acc_q[30:0], 1'b0};
  end

  always_comb begin
    prod_fix = neg_q ? (64'd0 - acc_q) : acc_q;
    quo_fix  = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    rem_fix  = rem_neg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
  end

  // Datapath next-state
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    rs_raw_d  = rs_raw_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (md_start) begin
          case (md_op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              acc_d     = {32'd0, rs_abs};
              opb_d     = rt_abs;
              cnt_d     = 5'd31;
              rs_raw_d  = rs_data;
              is_div_d  = md_op[1];
              neg_d     = op_signed && (rs_data[31] ^ rt_data[31]);
              rem_neg_d = op_signed && rs_data[31];
              dz_d      = (rt_data == 32'd0);
            end
            OP_MTHI: hi_d = rs_data;
            OP_MTLO: lo_d = rs_data;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
      end
      S_FIX: begin
        done_d = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (dz_q) begin
          // Divide by zero: all-ones quotient, raw dividend as remainder
          hi_d = rs_raw_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      opb_q     <= 32'd0;
      rs_raw_q  <= 32'd0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      rs_raw_q  <= rs_raw_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    hi       = hi_q;
    lo       = lo_q;
    md_done  = done_q;
    md_stall = md_busy && mf_req;
    mf_data  = mf_sel ? hi_q : lo_q;
  end

endmodule
